// File: rtl/add2_pkg.sv
// add2_pkg: register map, CTRL bit positions, response codes and adder FSM states
package add2_pkg;
  localparam logic [3:0] OFF_OPA = 4'h0;
  localparam logic [3:0] OFF_OPB = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_DONE = 2;
  localparam int CTRL_CARRY = 3;
  localparam int CTRL_IE = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? din[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/add2_axil_core_if.sv
// add2_axil_if: AXI4-Lite channel bundle with master/slave views
interface add2_axil_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata, rdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/add2_datapath.sv
// add2_datapath: operand snapshot, registered 33-bit sum, then result/carry registers
module add2_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        sum_vld,
  output logic [31:0] result,
  output logic        carry
);
  logic [31:0] a_q, b_q;
  logic [32:0] sum_q;
  logic snap_vld;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      snap_vld <= 1'b0;
      sum_vld <= 1'b0;
      result <= '0;
      carry <= 1'b0;
    end else begin
      snap_vld <= start;
      sum_vld <= snap_vld;
      if (start) begin
        a_q <= opa;
        b_q <= opb;
      end
      if (snap_vld) sum_q <= {1'b0, a_q} + {1'b0, b_q};
      if (sum_vld) begin
        result <= sum_q[31:0];
        carry <= sum_q[32];
      end
    end
endmodule

// File: rtl/add2_axil_core.sv
// add2_axil_core: AXI4-Lite slave around a two-cycle 32-bit adder with carry and done interrupt
module add2_axil_core
  import add2_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  add2_axil_if.slave s_axi,
  output logic       irq
);
  localparam int AI = C_S_AXI_ADDR_WIDTH - 1;
  logic [1:0] rst_sync;
  logic rst_n, aw_hs, w_hs, ar_hs, aw_full, w_full, wr, ctrl_wr, start, clr_done, ie, sum_vld, carry;
  logic [AI:2] aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data, opa, opb, result, ctrl_val, rd_val;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
  logic unused_ok;
  state_t state;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign wr = aw_full && w_full;
  assign ctrl_wr = wr && aw_idx == OFF_CTRL[3:2] && w_strb[0];
  assign start = ctrl_wr && w_data[CTRL_START] && state != ST_CALC;
  assign clr_done = ctrl_wr && w_data[CTRL_DONE];
  // readies gated by the synchronised reset so they stay low until release completes
  assign s_axi.awready = rst_n && !aw_full && !s_axi.bvalid;
  assign s_axi.wready = rst_n && !w_full && !s_axi.bvalid;
  assign s_axi.arready = rst_n && !s_axi.rvalid;
  assign s_axi.bresp = RESP_OKAY;
  assign s_axi.rresp = RESP_OKAY;
  assign irq = state == ST_DONE && ie;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
  always_comb begin
    ctrl_val = '0;
    ctrl_val[CTRL_BUSY] = state == ST_CALC;
    ctrl_val[CTRL_DONE] = state == ST_DONE;
    ctrl_val[CTRL_CARRY] = carry;
    ctrl_val[CTRL_IE] = ie;
  end
  assign rd_val = s_axi.araddr[AI:2] == OFF_OPA[3:2] ? opa :
                  s_axi.araddr[AI:2] == OFF_OPB[3:2] ? opb :
                  s_axi.araddr[AI:2] == OFF_CTRL[3:2] ? ctrl_val : result;
  add2_datapath u_dp (
    .clk(ACLK), .rst_n(rst_n), .start(start), .opa(opa), .opb(opb),
    .sum_vld(sum_vld), .result(result), .carry(carry)
  );
  always_ff @(posedge ACLK or negedge rst_n)
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      opa <= '0;
      opb <= '0;
      ie <= 1'b0;
      state <= ST_IDLE;
      s_axi.bvalid <= 1'b0;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata <= '0;
    end else begin
      aw_full <= !wr && (aw_full || aw_hs);
      w_full <= !wr && (w_full || w_hs);
      if (aw_hs) aw_idx <= s_axi.awaddr[AI:2];
      if (w_hs) begin
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (wr && aw_idx == OFF_OPA[3:2]) opa <= byte_merge(opa, w_data, w_strb);
      if (wr && aw_idx == OFF_OPB[3:2]) opb <= byte_merge(opb, w_data, w_strb);
      if (ctrl_wr) ie <= w_data[CTRL_IE];
      state <= start ? ST_CALC :
               state == ST_CALC && sum_vld ? ST_DONE :
               state == ST_DONE && clr_done ? ST_IDLE : state;
      s_axi.bvalid <= wr || (s_axi.bvalid && !s_axi.bready);
      s_axi.rvalid <= ar_hs || (s_axi.rvalid && !s_axi.rready);
      if (ar_hs) s_axi.rdata <= rd_val;
    end
endmodule

// File: tb/tb_add2_axil_core.sv
// tb_add2_axil_core: directed and randomized AXI4-Lite traffic against a transaction-level adder model
module tb_add2_axil_core;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic irq;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  logic [31:0] m_opa, m_opb, m_result, got;
  logic [32:0] m_sum;
  logic m_ie, m_done, m_carry, m_active;
  int m_fin;

  add2_axil_if bif ();
  add2_axil_core dut (.ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bif.slave), .irq(irq));

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // model: register state as seen after a given clock edge
  function automatic void m_reset();
    m_opa = 0; m_opb = 0; m_result = 0; m_sum = 0;
    m_ie = 0; m_done = 0; m_carry = 0; m_active = 0; m_fin = 0;
  endfunction

  function automatic void m_adv(input int e);
    if (m_active && m_fin <= e) begin
      m_result = m_sum[31:0];
      m_carry = m_sum[32];
      m_done = 1;
      m_active = 0;
    end
  endfunction

  function automatic void m_write(input int e, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    m_adv(e - 1);
    for (int i = 0; i < 4; i++) begin
      if (s[i] && addr[3:2] == 2'd0) m_opa[8*i+:8] = d[8*i+:8];
      if (s[i] && addr[3:2] == 2'd1) m_opb[8*i+:8] = d[8*i+:8];
    end
    if (addr[3:2] == 2'd2 && s[0]) begin
      m_ie = d[4];
      if (d[0] && !m_active) begin
        m_sum = {1'b0, m_opa} + {1'b0, m_opb};
        m_active = 1;
        m_fin = e + 2;
        m_done = 0;
      end else if (d[2]) m_done = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(input int e, input logic [3:0] addr);
    m_adv(e - 1);
    case (addr[3:2])
      2'd0: return m_opa;
      2'd1: return m_opb;
      2'd2: return {27'd0, m_ie, m_carry, m_done, m_active, 1'b0};
      default: return m_result;
    endcase
  endfunction

  task automatic chk_irq(input string tag);
    m_adv(cyc);
    chk(tag, irq, m_done & m_ie);
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s, input int lead, input int bdly);
    bit awd, wd, ah, wh;
    int k, n;
    awd = 0; wd = 0; k = 0;
    bif.awaddr = addr; bif.awprot = 3'($urandom); bif.wdata = d; bif.wstrb = s;
    while (!(awd && wd) && k < 50) begin
      if (!awd && k >= (lead < 0 ? 0 : lead)) bif.awvalid = 1;
      if (!wd && k >= (lead > 0 ? 0 : -lead)) bif.wvalid = 1;
      ah = bif.awvalid && bif.awready;
      wh = bif.wvalid && bif.wready;
      @(negedge ACLK);
      if (ah) begin bif.awvalid = 0; awd = 1; end
      if (wh) begin bif.wvalid = 0; wd = 1; end
      k++;
    end
    bif.awvalid = 0; bif.wvalid = 0;
    if (!(awd && wd)) begin chk("aw_w_accept", {awd, wd}, 2'b11); return; end
    n = 0;
    while (!bif.bvalid && n < 10) begin @(negedge ACLK); n++; end
    if (!bif.bvalid) begin chk("bvalid_wait", bif.bvalid, 1); return; end
    m_write(cyc, addr, d, s);
    for (int i = 0; i < bdly; i++) begin
      chk("bvalid_hold", bif.bvalid, 1);
      chk("aw_w_blocked", {bif.awready, bif.wready}, 2'b00);
      @(negedge ACLK);
    end
    chk("bresp", bif.bresp, 2'b00);
    bif.bready = 1;
    @(negedge ACLK);
    bif.bready = 0;
    chk("bvalid_clear", bif.bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input string tag, output logic [31:0] data);
    bit h;
    int n;
    h = 0; n = 0; data = 'x;
    bif.araddr = addr; bif.arprot = 3'($urandom); bif.arvalid = 1;
    while (!h && n < 50) begin h = bif.arready; @(negedge ACLK); n++; end
    bif.arvalid = 0;
    if (!h) begin chk("arready_wait", h, 1); return; end
    chk({tag, "_rvalid"}, bif.rvalid, 1);
    chk(tag, bif.rdata, m_read(cyc, addr));
    chk({tag, "_rresp"}, bif.rresp, 2'b00);
    data = bif.rdata;
    bif.rready = 1;
    @(negedge ACLK);
    bif.rready = 0;
  endtask

  // START write with bready held low while a read runs underneath it
  task automatic start_with_read(input logic [31:0] ctrl, input int rd_delay, input logic [3:0] raddr, input string tag, output logic [31:0] data);
    int n;
    n = 0;
    fork
      axi_write(4'h8, ctrl, 4'hF, 0, 4);
      begin
        while (!bif.bvalid && n < 20) begin @(negedge ACLK); n++; end
        #1;
        repeat (rd_delay) @(negedge ACLK);
        axi_read(raddr, tag, data);
      end
    join
  endtask

  initial begin
    bit [3:0] a, s;
    logic [31:0] d;
    int n;
    m_reset();
    {bif.awvalid, bif.wvalid, bif.bready, bif.arvalid, bif.rready} = '0;
    bif.awaddr = 0; bif.araddr = 0; bif.awprot = 0; bif.arprot = 0; bif.wdata = 0; bif.wstrb = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", bif.awready, 0);
    chk("rst_wready", bif.wready, 0);
    chk("rst_bvalid", bif.bvalid, 0);
    chk("rst_arready", bif.arready, 0);
    chk("rst_rvalid", bif.rvalid, 0);
    chk("rst_irq", irq, 0);
    ARESETN = 1;
    n = 0;
    while (!bif.awready && n < 10) begin @(negedge ACLK); n++; end
    chk("release_awready", bif.awready, 1);

    axi_write(4'h0, 32'h1, 4'hF, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 1, 0);
    axi_write(4'h8, 32'h3, 4'hE, -1, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 1);
    axi_read(4'h0, "rb_opa", got);
    axi_read(4'h5, "rb_opb", got);
    axi_read(4'hA, "rb_ctrl", got);
    axi_read(4'hF, "rb_result", got);
    chk("rb_result_ignored", got, 32'h0);

    axi_write(4'h0, 32'h5, 4'hF, 0, 0);
    axi_write(4'h4, 32'hA, 4'hF, 0, 0);
    start_with_read(32'h11, 0, 4'h8, "ctrl_busy", got);
    chk("busy_bit", got[1], 1);
    repeat (2) @(negedge ACLK);
    axi_read(4'hC, "sum_5_a", got);
    chk("sum_5_a_value", got, 32'hF);
    axi_read(4'h8, "ctrl_done", got);
    chk("ctrl_done_value", got, 32'h14);
    chk("irq_done", irq, 1);

    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(4'h4, 32'h1, 4'hF, 0, 0);
    start_with_read(32'h11, 1, 4'hC, "result_pre_update", got);
    chk("pre_update_value", got, 32'hF);
    repeat (2) @(negedge ACLK);
    axi_read(4'hC, "wrap_result", got);
    chk("wrap_result_value", got, 32'h0);
    axi_read(4'h8, "wrap_ctrl", got);
    chk("wrap_carry", got[3], 1);
    axi_write(4'h8, 32'h4, 4'hF, 0, 0);
    chk("irq_cleared", irq, 0);
    axi_read(4'h8, "ctrl_w1c", got);
    chk("done_cleared", got[2], 0);

    axi_write(4'h0, 32'hA5A5_0001, 4'h3, 3, 5);
    axi_read(4'h0, "strb_opa", got);

    axi_write(4'h4, 32'h10, 4'hF, 0, 0);
    axi_write(4'h8, 32'h11, 4'hF, 0, 0);
    axi_write(4'h8, 32'h11, 4'hF, 0, 0);
    axi_write(4'h4, 32'h20, 4'hF, -2, 0);
    repeat (3) @(negedge ACLK);
    axi_read(4'hC, "restart_result", got);
    chk_irq("restart_irq");

    for (int it = 0; it < 60; it++) begin
      a = 4'($urandom);
      s = 4'($urandom);
      d = a[3:2] == 2'd2 ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 9) < 6) axi_write(a, d, s, $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      else axi_read(a, "rnd_read", got);
      repeat ($urandom_range(0, 3)) @(negedge ACLK);
      chk_irq("rnd_irq");
    end

    @(negedge ACLK);
    chk("pre_rst_awready", bif.awready, 1);
    bif.awaddr = 4'h8; bif.wdata = 32'h1; bif.wstrb = 4'h1;
    bif.awvalid = 1; bif.wvalid = 1;
    @(negedge ACLK);
    bif.awvalid = 0; bif.wvalid = 0;
    @(negedge ACLK);
    chk("mid_rst_bvalid", bif.bvalid, 1);
    #1 ARESETN = 0;
    #1;
    chk("arst_awready", bif.awready, 0);
    chk("arst_wready", bif.wready, 0);
    chk("arst_bvalid", bif.bvalid, 0);
    chk("arst_arready", bif.arready, 0);
    chk("arst_rvalid", bif.rvalid, 0);
    chk("arst_irq", irq, 0);
    m_reset();
    @(negedge ACLK);
    ARESETN = 1;
    repeat (4) @(negedge ACLK);
    chk("post_rst_bvalid", bif.bvalid, 0);
    axi_read(4'h0, "post_rst_opa", got);
    axi_read(4'h4, "post_rst_opb", got);
    axi_read(4'h8, "post_rst_ctrl", got);
    axi_read(4'hC, "post_rst_result", got);
    chk("post_rst_result_value", got, 32'h0);
    repeat (4) @(negedge ACLK);
    chk("post_rst_no_b", bif.bvalid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
